// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between program_counter and decode.
//   Issues one imem request at a time from pc_in, buffers returned words with their PC in a
//   small registered FIFO, and computes program_counter's next PC (redirect / PC+4 / hold).
// Latency: a response is visible on inst_* the cycle after it arrives; pc_next is combinational.
// Backpressure: no request is issued while the FIFO is full; inst_ready=0 stalls the fetch
//   stream. imem_req_valid/addr stay stable until imem_req_ready, unless a redirect intervenes.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   pc_in / pc_next                program_counter PC_out / PC_in
//   redirect_valid/_target         branch/jump redirect, flushes the buffer
//   imem_req_valid/_ready/_addr    request channel (one outstanding)
//   imem_rsp_valid/_data           in-order response words
//   inst_valid/_ready/_data/_pc    buffered instruction stream to decode
// Optional feature macro FETCH_MISALIGN_CHECK_EN: adds output inst_fault. A misaligned pc_in
//   produces a single faulting entry instead of a request, and fetch stalls until a redirect.
//   Without it, the request address is forced word-aligned.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            inst_fault,
`endif
  output logic [XLEN-1:0] inst_pc
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
    logic            fault;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [XLEN-1:0] pc_issue_q, pc_issue_d;

  logic   fifo_full;
  logic   misalign;
  logic   req_fire;
  logic   rsp_push;
  logic   push;
  logic   push_ok;
  logic   pop;
  entry_t new_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Set once the fault entry has been pushed; stops further fetch until a redirect.
  logic fault_hold_q, fault_hold_d;
  logic fault_push;
`endif

  assign fifo_full = (count_q == DEPTH_C);
  assign pop       = inst_ready && (count_q != '0);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign   = (pc_in[1:0] != 2'b00);
  assign fault_push = (state_q == S_REQ) && misalign && !fault_hold_q && !fifo_full
                      && !redirect_valid && !reset;
`else
  assign misalign   = 1'b0;
`endif

  // reset gates the request so nothing leaves the block while held in reset.
  assign imem_req_valid = (state_q == S_REQ) && !fifo_full && !redirect_valid
                          && !misalign && !reset
`ifdef FETCH_MISALIGN_CHECK_EN
                          && !fault_hold_q
`endif
                          ;
  assign req_fire = imem_req_valid && imem_req_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign imem_req_addr = pc_in;
`else
  assign imem_req_addr = {pc_in[XLEN-1:2], 2'b00};
`endif

  // Next-PC select; the adder wraps naturally at 2^XLEN.
  always_comb begin
    pc_next = pc_in;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_target;
    end else if (req_fire) begin
      pc_next = pc_in + XLEN'(4);
    end
  end

  // A response is only kept when it belongs to a live request: in S_WAIT and not
  // coinciding with a redirect (which makes it stale).
  assign rsp_push = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign push = rsp_push || fault_push;
`else
  assign push = rsp_push;
`endif
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_ok = push && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_issue_d = pc_issue_q;
    mem_d      = mem_q;
    new_entry  = '{pc: pc_issue_q, data: imem_rsp_data, fault: 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_hold_d = fault_hold_q;
    if (fault_push) begin
      new_entry    = '{pc: pc_in, data: 32'h0, fault: 1'b1};
      fault_hold_d = 1'b1;
    end
    if (redirect_valid) begin
      fault_hold_d = 1'b0;
    end
`endif

    if (req_fire) begin
      pc_issue_d = pc_in;
    end

    case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Response wins over redirect: the request is complete, so no drain is needed.
        if (imem_rsp_valid)      state_d = S_REQ;
        else if (redirect_valid) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_issue_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_hold_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_issue_q <= pc_issue_d;
      mem_q      <= mem_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_hold_q <= fault_hold_d;
`endif
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst_data  = mem_q[rd_ptr_q].data;
  assign inst_pc    = mem_q[rd_ptr_q].pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign inst_fault = inst_valid && mem_q[rd_ptr_q].fault;
`endif

endmodule
